// File: rtl/mole_spawner.sv
// Whack-a-mole spawner: LFSR-driven hole picker with retry/fallback, hit/miss
// scoring and a full-display flash after an accepted hit.
module mole_spawner #(
  parameter int unsigned NUM_HOLES    = 18,
  parameter logic [15:0] SEED         = 16'hACE1,
  parameter int unsigned FLASH_CYCLES = 25_000_000,
  parameter int unsigned MAX_TRIES    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        trigger,
  input  logic        mole_hit,
  output logic [4:0]  position,
  output logic [17:0] display,
  output logic        mole_active,
  output logic        hit_ack,
  output logic [11:0] hit_count,
  output logic [11:0] miss_count
);

  localparam logic [15:0]  SEED_INIT  = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam int unsigned  FW         = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
  localparam int unsigned  TW         = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_CYCLES - 1);
  localparam logic [TW-1:0] TRY_LAST   = TW'(MAX_TRIES - 1);
  localparam logic [4:0]   HOLES      = 5'(NUM_HOLES);
  localparam logic [4:0]   HOLE_LAST  = 5'(NUM_HOLES - 1);
  localparam logic [4:0]   NO_MOLE    = 5'd31;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PICK,
    S_SHOW,
    S_FLASH
  } state_e;

  state_e        state_q, state_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [4:0]    pos_q, pos_d;
  logic          last_valid_q, last_valid_d;
  logic [TW-1:0] tries_q, tries_d;
  logic [FW-1:0] flash_q, flash_d;
  logic          hit_ack_q, hit_ack_d;
  logic [11:0]   hit_cnt_q, hit_cnt_d;
  logic [11:0]   miss_cnt_q, miss_cnt_d;

  logic [4:0]    cand;
  logic          cand_ok;
  logic [4:0]    fallback;

  always_comb begin
    state_d      = state_q;
    lfsr_d       = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    pos_d        = pos_q;
    last_valid_d = last_valid_q;
    tries_d      = tries_q;
    flash_d      = flash_q;
    hit_ack_d    = 1'b0;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;

    // pos_q doubles as the last shown position; the output is masked outside SHOW
    cand     = lfsr_q[4:0];
    cand_ok  = (cand < HOLES) && !(last_valid_q && (cand == pos_q));
    fallback = 5'd0;
    if (last_valid_q && (pos_q != HOLE_LAST)) begin
      fallback = pos_q + 5'd1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (trigger) begin
          state_d = S_PICK;
          tries_d = '0;
        end
      end
      S_PICK: begin
        if (cand_ok) begin
          pos_d        = cand;
          last_valid_d = 1'b1;
          state_d      = S_SHOW;
        end else if (tries_q == TRY_LAST) begin
          pos_d        = fallback;
          last_valid_d = 1'b1;
          state_d      = S_SHOW;
        end else begin
          tries_d = tries_q + TW'(1);
        end
      end
      S_SHOW: begin
        if (mole_hit) begin
          hit_ack_d = 1'b1;
          if (hit_cnt_q != '1) begin
            hit_cnt_d = hit_cnt_q + 12'd1;
          end
          if (trigger) begin
            state_d = S_PICK;
            tries_d = '0;
          end else begin
            state_d = S_FLASH;
            flash_d = '0;
          end
        end else if (trigger) begin
          if (miss_cnt_q != '1) begin
            miss_cnt_d = miss_cnt_q + 12'd1;
          end
          state_d = S_PICK;
          tries_d = '0;
        end
      end
      S_FLASH: begin
        if (trigger) begin
          state_d = S_PICK;
          tries_d = '0;
        end else if (flash_q == FLASH_LAST) begin
          state_d = S_IDLE;
        end else begin
          flash_d = flash_q + FW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      lfsr_q       <= SEED_INIT;
      pos_q        <= '0;
      last_valid_q <= 1'b0;
      tries_q      <= '0;
      flash_q      <= '0;
      hit_ack_q    <= 1'b0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      pos_q        <= pos_d;
      last_valid_q <= last_valid_d;
      tries_q      <= tries_d;
      flash_q      <= flash_d;
      hit_ack_q    <= hit_ack_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  always_comb begin
    position    = NO_MOLE;
    display     = '0;
    mole_active = 1'b0;
    if (state_q == S_SHOW) begin
      position    = pos_q;
      display     = 18'd1 << pos_q;
      mole_active = 1'b1;
    end else if (state_q == S_FLASH) begin
      display = '1;
    end
  end

  assign hit_ack    = hit_ack_q;
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_mole_spawner.sv
// Directed bench for mole_spawner: vector table plus multi-cycle sequences,
// with an LFSR reference to predict each picked hole and its latency.
module tb_mole_spawner;

  localparam int unsigned NH     = 18;
  localparam int unsigned MT     = 8;
  localparam int unsigned FC     = 4;
  localparam logic [15:0] SEED16 = 16'hACE1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        trigger = 1'b0;
  logic        mole_hit = 1'b0;
  logic [4:0]  position;
  logic [17:0] display;
  logic        mole_active;
  logic        hit_ack;
  logic [11:0] hit_count;
  logic [11:0] miss_count;

  mole_spawner #(
    .NUM_HOLES   (NH),
    .SEED        (SEED16),
    .FLASH_CYCLES(FC),
    .MAX_TRIES   (MT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .trigger    (trigger),
    .mole_hit   (mole_hit),
    .position   (position),
    .display    (display),
    .mole_active(mole_active),
    .hit_ack    (hit_ack),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [15:0] lfsr_m;
  logic [4:0]  last_m = 5'd0;
  bit          lv_m = 1'b0;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  always @(posedge clk) lfsr_m <= reset ? SEED16 : lfsr_next(lfsr_m);

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s [%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic predict(input logic [15:0] l0, input logic [4:0] last, input bit lv,
                         output logic [4:0] pos, output int unsigned lat);
    logic [15:0] l;
    bit found;
    l     = l0;
    found = 1'b0;
    pos   = 5'd0;
    lat   = MT + 1;
    for (int t = 0; t < int'(MT); t++) begin
      if (!found) begin
        l = lfsr_next(l);
        if ((32'(l[4:0]) < NH) && !(lv && (l[4:0] == last))) begin
          found = 1'b1;
          pos   = l[4:0];
          lat   = t + 2;
        end
      end
    end
    if (!found) pos = (lv && (32'(last) != NH - 1)) ? last + 5'd1 : 5'd0;
  endtask

  task automatic step(input bit r, input bit t, input bit h);
    reset    = r;
    trigger  = t;
    mole_hit = h;
    @(negedge clk);
    reset    = 1'b0;
    trigger  = 1'b0;
    mole_hit = 1'b0;
    if (r) lv_m = 1'b0;
  endtask

  // Trigger a new mole, optionally with a simultaneous hit, and optionally
  // poke trigger/mole_hit during the first PICK cycle; wait for SHOW.
  task automatic show_wait(input bit h, input bit exp_ack, input bit pick_trg,
                           input bit pick_hit, input int idx);
    logic [4:0]  ppos;
    int unsigned plat;
    int unsigned lat;
    predict(lfsr_m, last_m, lv_m, ppos, plat);
    trigger  = 1'b1;
    mole_hit = h;
    @(negedge clk);
    trigger  = pick_trg;
    mole_hit = pick_hit;
    check("ack_first", idx, 32'(hit_ack), 32'(exp_ack));
    check("pick_dark", idx, {13'd0, mole_active, display}, 32'd0);
    check("pick_pos31", idx, 32'(position), 32'd31);
    lat = 1;
    while (mole_active !== 1'b1 && lat < MT + 2) begin
      @(negedge clk);
      trigger  = 1'b0;
      mole_hit = 1'b0;
      lat++;
      check("ack_late", idx, 32'(hit_ack), 32'd0);
    end
    check("show_active", idx, 32'(mole_active), 32'd1);
    check("latency", idx, lat, plat);
    check("position", idx, 32'(position), 32'(ppos));
    check("in_range", idx, 32'(32'(position) < NH), 32'd1);
    check("onehot", idx, 32'(display), 32'(18'd1 << ppos));
    if (lv_m) check("distinct", idx, 32'(position != last_m), 32'd1);
    last_m = ppos;
    lv_m   = 1'b1;
  endtask

  typedef struct {
    bit rst, trg, hit, wshow;
    bit e_act, e_ack, e_ones;
    int unsigned e_hits, e_miss;
  } vec_t;

  vec_t tbl[19];

  initial begin
    //          rst trg hit wsh  act ack ones hits miss
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1, 0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1, 0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2, 1};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2, 2};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3, 2};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3, 2};
    tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3, 2};
    tbl[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4, 2};
    tbl[17] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
    tbl[18] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0};

    for (int i = 0; i < 19; i++) begin
      if (tbl[i].wshow) begin
        show_wait(tbl[i].hit, tbl[i].e_ack, 1'b0, 1'b0, i);
      end else begin
        step(tbl[i].rst, tbl[i].trg, tbl[i].hit);
        check("hit_ack", i, 32'(hit_ack), 32'(tbl[i].e_ack));
      end
      check("active", i, 32'(mole_active), 32'(tbl[i].e_act));
      check("hit_count", i, 32'(hit_count), tbl[i].e_hits);
      check("miss_count", i, 32'(miss_count), tbl[i].e_miss);
      if (tbl[i].e_ones) begin
        check("flash_disp", i, 32'(display), 32'h3FFFF);
        check("flash_pos", i, 32'(position), 32'd31);
      end else if (tbl[i].e_act) begin
        check("show_disp", i, 32'(display), 32'(18'd1 << last_m));
        check("show_pos", i, 32'(position), 32'(last_m));
      end else begin
        check("dark_disp", i, 32'(display), 32'd0);
        check("dark_pos", i, 32'(position), 32'd31);
      end
    end

    // Hit and trigger poked during PICK are both ignored; the trigger from SHOW is a miss
    show_wait(1'b0, 1'b0, 1'b1, 1'b1, 100);
    check("pick_hit_count", 100, 32'(hit_count), 32'd0);
    check("pick_miss_count", 100, 32'(miss_count), 32'd1);

    step(1'b1, 1'b0, 1'b0);
    check("rst_counts", 200, {8'd0, hit_count, miss_count}, 32'd0);
    for (int i = 0; i < 1000; i++) show_wait(1'b0, 1'b0, 1'b0, 1'b0, 1000 + i);
    check("miss_999", 200, 32'(miss_count), 32'd999);
    check("hits_0", 200, 32'(hit_count), 32'd0);

    for (int i = 0; i < 4100; i++) show_wait(1'b1, 1'b1, 1'b0, 1'b0, 10000 + i);
    check("hit_sat", 300, 32'(hit_count), 32'd4095);
    check("miss_kept", 300, 32'(miss_count), 32'd999);

    for (int i = 0; i < 4100; i++) show_wait(1'b0, 1'b0, 1'b0, 1'b0, 20000 + i);
    check("miss_sat", 400, 32'(miss_count), 32'd4095);
    check("hit_held", 400, 32'(hit_count), 32'd4095);

    step(1'b0, 1'b0, 1'b1);
    check("sat_ack", 500, 32'(hit_ack), 32'd1);
    check("sat_flash", 500, 32'(display), 32'h3FFFF);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("rst_flash_disp", 500, 32'(display), 32'd0);
    check("rst_flash_pos", 500, 32'(position), 32'd31);
    check("rst_flash_out", 500, {6'd0, mole_active, hit_ack, hit_count, miss_count}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
